sync_fifo_gearbox: RTL and testbench
====================================

# sync_fifo_gearbox

Single-clock FIFO with parametrised depth, data width and read-width ratio: narrow write, wide read. Each accepted read pops RD_RATIO consecutive entries and presents them concatenated on a registered output. This generalises the fixed two-entry concatenating FIFO memory. It adds full pointer/level management, a guard that pops only when RD_RATIO entries are present, an almost-full flag, synchronous flush and sticky error flags. It sits between the byte-wide producer and word-wide consumer stages of the datapath.

## Interface
- DATA_WIDTH, 8, width of one write entry
- FIFO_DEPTH, 16, number of entries; power of two, ≥ 2·RD_RATIO, multiple of RD_RATIO
- RD_RATIO, 2, entries popped per read; power of two, ≥ 1
- AFULL_THRESH, 12, level at or above which wafull asserts; 1..FIFO_DEPTH
- ADDR_WIDTH (localparam), clog2(FIFO_DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of pointers, level and sticky flags
- wr_data  in  DATA_WIDTH  write entry
- winc  in  1  write request
- wfull  out  1  level == FIFO_DEPTH
- wafull  out  1  level ≥ AFULL_THRESH
- rinc  in  1  read request
- rempty  out  1  level < RD_RATIO
- rd_data  out  RD_RATIO·DATA_WIDTH  popped group; oldest entry in LSBs
- rd_data_valid  out  1  rd_data updated this cycle
- level  out  ADDR_WIDTH+1  entries currently stored
- overflow  out  1  sticky: write attempted while wfull
- underflow  out  1  sticky: read attempted while rempty

## Operation
- Reset (rst=1, async) sets: wr_ptr=0, rd_ptr=0, level=0, memory all zeros, rd_data=0, rd_data_valid=0, overflow=0, underflow=0. Derived outputs: rempty=1, wfull=0, wafull=0.
- wfull, rempty and wafull are combinational decodes of the level register. They never depend on same-cycle winc/rinc.
- Write accept condition: wen = winc & !wfull & !flush. On wen, mem[wr_ptr] ← wr_data and wr_ptr ← wr_ptr+1 (mod FIFO_DEPTH).
- Read accept condition: ren = rinc & !rempty & !flush.
  - On ren, rd_data ← {mem[rd_ptr+RD_RATIO-1], …, mem[rd_ptr]} and rd_ptr ← rd_ptr+RD_RATIO (mod FIFO_DEPTH).
  - rd_data_valid=1 for exactly that following cycle, otherwise 0.
  - rd_data holds its last value when no read is accepted.
- rd_ptr is always a multiple of RD_RATIO, so a popped group never straddles the wrap point.
- Level update, all in ADDR_WIDTH+1 bits: level_next = level + wen − RD_RATIO·ren.
- Simultaneous wen and ren are both honoured, with eligibility judged on the pre-edge level. A read never needs the same-cycle write data, so there is no bypass path.
- winc while wfull (and no flush): write dropped, overflow ← 1.
- rinc while rempty (and no flush): no pop, rd_data unchanged, rd_data_valid=0, underflow ← 1.
- A partial group (0 < level < RD_RATIO) stays stored and is popped once the group completes.
- Flush has priority over winc/rinc in the same cycle. It sets wr_ptr, rd_ptr and level to 0 and clears overflow, underflow and rd_data_valid. Memory and rd_data are untouched.
- Reset asserted mid-operation aborts everything immediately; the state after deassertion is identical to power-on reset.
- RD_RATIO=1 degenerates to a plain synchronous FIFO with 1-cycle registered read.

## Timing
- Write-to-flag latency is 1 cycle: level, wfull, wafull and rempty reflect a write on the edge after it is accepted.
- Read latency is 1 cycle: rinc accepted at edge N gives rd_data and rd_data_valid valid after edge N, for one cycle only.
- Minimum latency from first write to possible read is RD_RATIO write cycles, plus 1 cycle to the rd_data output.
- Sustained throughput: 1 write/cycle and 1 read per RD_RATIO cycles, with no bubbles at full or empty boundaries.
- Flags are glitch-free registered-decode outputs, with no combinational path from winc/rinc.

## Test plan
- Reset: rst pulse mid-stream → every output at its reset value within the same cycle (async); rempty=1, level=0.
- Fill/drain (defaults):
  - Write 0x01..0x10 → wfull=1 and level=16 after the 16th edge; wafull first rises at level 12.
  - Then 8 reads → rd_data 0x0201, 0x0403, …, 0x100F, each with 1-cycle valid; rempty=1 at the end.
- Partial group: write 0xA1, 0xA2, 0xA3 → rempty=0.
  - Read → 0xA2A1, level=1, rempty=1.
  - Further rinc → underflow=1, rd_data stays 0xA2A1.
  - Write 0xA4, then read → 0xA4A3.
- Wrap plus simultaneous traffic: continuous winc every cycle and rinc every cycle for 100 cycles with an incrementing data pattern.
  - Popped words match a scoreboard in order.
  - level steady-states without overflow; pointer wrap is correct.
- Overflow and flush:
  - Fill to 16, then write 0xFF → overflow=1, level stays 16, 0xFF never read.
  - Assert flush together with winc/rinc → next cycle level=0, overflow=0, rd_data_valid=0.
- RD_RATIO=4, FIFO_DEPTH=8 build: write 0x10..0x17, two reads → 0x13121110, then 0x17161514.

Source files
------------

// File: rtl/sync_fifo_gearbox.sv
// ---------------------------------------------------------------------------
// sync_fifo_gearbox
//
// Single-clock FIFO with a narrow write side and a wide read side. Every
// accepted write stores one DATA_WIDTH entry. Every accepted read pops
// RD_RATIO consecutive entries and presents them concatenated on a registered
// output, with the oldest entry in the least significant bits.
//
// Ports:
//   clk_i            rising-edge clock for all state
//   rst_i            asynchronous active-high reset
//   flush_i          synchronous clear of pointers, level and sticky flags
//   wr_data_i        write entry (DATA_WIDTH)
//   winc_i           write request
//   wfull_o          level == FIFO_DEPTH
//   wafull_o         level >= AFULL_THRESH
//   rinc_i           read request
//   rempty_o         level < RD_RATIO (no complete group stored)
//   rd_data_o        popped group (RD_RATIO*DATA_WIDTH), oldest entry in LSBs
//   rd_data_valid_o  rd_data_o was updated by the previous edge
//   level_o          number of entries currently stored
//   overflow_o       sticky: write attempted while full
//   underflow_o      sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_gearbox #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int RD_RATIO     = 2,
    parameter int AFULL_THRESH = 12,
    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           winc_i,
    output logic                           wfull_o,
    output logic                           wafull_o,
    input  logic                           rinc_i,
    output logic                           rempty_o,
    output logic [RD_RATIO*DATA_WIDTH-1:0] rd_data_o,
    output logic                           rd_data_valid_o,
    output logic [ADDR_WIDTH:0]            level_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int LVL_W = ADDR_WIDTH + 1;
    localparam int RD_W  = RD_RATIO * DATA_WIDTH;

    localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]      LVL_AFULL = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0]      LVL_GROUP = LVL_W'(RD_RATIO);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_GROUP = ADDR_WIDTH'(RD_RATIO);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [RD_W-1:0]       rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full, empty, wen, ren;
    logic [RD_W-1:0]       rd_group;

    // Flags decode only the level register, so they carry no path from the
    // same-cycle requests.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q < LVL_GROUP);

    assign wen = winc_i & ~full  & ~flush_i;
    assign ren = rinc_i & ~empty & ~flush_i;

    // rd_ptr only ever advances in whole groups from 0, so the group below
    // never straddles the wrap point.
    generate
        for (genvar gi = 0; gi < RD_RATIO; gi++) begin : g_gather
            assign rd_group[gi*DATA_WIDTH +: DATA_WIDTH] =
                mem_q[rd_ptr_q + ADDR_WIDTH'(gi)];
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (winc_i && full) begin
                overflow_d = 1'b1;
            end
            if (rinc_i && empty) begin
                underflow_d = 1'b1;
            end
            if (wen) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (ren) begin
                rd_ptr_d   = rd_ptr_q + PTR_GROUP;
                rd_data_d  = rd_group;
                rd_valid_d = 1'b1;
            end
            // Both eligibilities were judged on the pre-edge level, so a
            // simultaneous push and pop never needs a bypass.
            level_d = level_q + LVL_W'(wen) - (ren ? LVL_GROUP : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is cleared by reset but deliberately left alone by flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign wfull_o         = full;
    assign wafull_o        = (level_q >= LVL_AFULL);
    assign rempty_o        = empty;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_valid_q;
    assign level_o         = level_q;
    assign overflow_o      = overflow_q;
    assign underflow_o     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_gearbox.sv
module tb_sync_fifo_gearbox;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int RATIO = 2;
    localparam int AFT   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default build
    logic             flush = 0, winc = 0, rinc = 0;
    logic [DW-1:0]    wr_data = '0;
    logic             wfull, wafull, rempty, rd_valid, ovf, udf;
    logic [RATIO*DW-1:0] rd_data;
    logic [4:0]       level;

    // RD_RATIO=4, FIFO_DEPTH=8 build
    logic             f4 = 0, w4 = 0, r4 = 0;
    logic [DW-1:0]    d4 = '0;
    logic             full4, afull4, empty4, v4, ovf4, udf4;
    logic [31:0]      rd4;
    logic [3:0]       lvl4;

    sync_fifo_gearbox #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RD_RATIO(RATIO),
                        .AFULL_THRESH(AFT)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_data_i(wr_data),
        .winc_i(winc), .wfull_o(wfull), .wafull_o(wafull), .rinc_i(rinc),
        .rempty_o(rempty), .rd_data_o(rd_data), .rd_data_valid_o(rd_valid),
        .level_o(level), .overflow_o(ovf), .underflow_o(udf));

    sync_fifo_gearbox #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .RD_RATIO(4),
                        .AFULL_THRESH(6)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(f4), .wr_data_i(d4),
        .winc_i(w4), .wfull_o(full4), .wafull_o(afull4), .rinc_i(r4),
        .rempty_o(empty4), .rd_data_o(rd4), .rd_data_valid_o(v4),
        .level_o(lvl4), .overflow_o(ovf4), .underflow_o(udf4));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: stored entries as a queue, plus output registers
    logic [DW-1:0]       mq[$];
    logic [RATIO*DW-1:0] m_rd    = '0;
    bit                  m_valid = 0, m_ovf = 0, m_udf = 0;

    typedef struct {
        bit          w, r, f;
        logic [7:0]  d;
        int          lvl;
        bit          empty, valid, ovf, udf;
        logic [15:0] rd;
        string       nm;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    endtask

    // Drive one cycle of requests, advance past the edge, update the model.
    task automatic cycle(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
        bit full_pre, empty_pre, acc_w, acc_r;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() < RATIO);
        acc_w = w && !full_pre && !f;
        acc_r = r && !empty_pre && !f;
        winc = w; rinc = r; flush = f; wr_data = d;
        @(posedge clk); #1;
        winc = 0; rinc = 0; flush = 0;
        if (f) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_valid = 0;
        end else begin
            if (w && full_pre)  m_ovf = 1;
            if (r && empty_pre) m_udf = 1;
            m_valid = acc_r;
            if (acc_r)
                for (int i = 0; i < RATIO; i++) m_rd[i*DW +: DW] = mq.pop_front();
            if (acc_w) mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"},  64'(level),    64'(mq.size()));
        chk({tag, ".rempty"}, 64'(rempty),   64'(mq.size() < RATIO));
        chk({tag, ".wfull"},  64'(wfull),    64'(mq.size() == DEPTH));
        chk({tag, ".wafull"}, 64'(wafull),   64'(mq.size() >= AFT));
        chk({tag, ".valid"},  64'(rd_valid), 64'(m_valid));
        chk({tag, ".rd"},     64'(rd_data),  64'(m_rd));
        chk({tag, ".ovf"},    64'(ovf),      64'(m_ovf));
        chk({tag, ".udf"},    64'(udf),      64'(m_udf));
    endtask

    task automatic cycle4(input bit w, input bit r, input logic [DW-1:0] d);
        w4 = w; r4 = r; d4 = d;
        @(posedge clk); #1;
        w4 = 0; r4 = 0;
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 8'hA1, 1, 1, 0, 0, 0, 16'h0000, "wr_a1"};
        vecs[1] = '{1, 0, 0, 8'hA2, 2, 0, 0, 0, 0, 16'h0000, "wr_a2"};
        vecs[2] = '{1, 0, 0, 8'hA3, 3, 0, 0, 0, 0, 16'h0000, "wr_a3"};
        vecs[3] = '{0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 16'hA2A1, "rd_a2a1"};
        vecs[4] = '{0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 16'hA2A1, "rd_under"};
        vecs[5] = '{1, 0, 0, 8'hA4, 2, 0, 0, 0, 1, 16'hA2A1, "wr_a4"};
        vecs[6] = '{0, 1, 0, 8'h00, 0, 1, 1, 0, 1, 16'hA4A3, "rd_a4a3"};
        vecs[7] = '{1, 1, 1, 8'h55, 0, 1, 0, 0, 0, 16'hA4A3, "flush_wr"};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model("reset");
        rst = 0;
        @(negedge clk);

        // ---------------- table: partial group, underflow, flush --------
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].d);
            $display("[TB] vec %0d %s lvl=%0d rd=%h v=%0b", i, vecs[i].nm, level, rd_data, rd_valid);
            chk({vecs[i].nm, ".level"},  64'(level),    64'(vecs[i].lvl));
            chk({vecs[i].nm, ".rempty"}, 64'(rempty),   64'(vecs[i].empty));
            chk({vecs[i].nm, ".valid"},  64'(rd_valid), 64'(vecs[i].valid));
            chk({vecs[i].nm, ".rd"},     64'(rd_data),  64'(vecs[i].rd));
            chk({vecs[i].nm, ".ovf"},    64'(ovf),      64'(vecs[i].ovf));
            chk({vecs[i].nm, ".udf"},    64'(udf),      64'(vecs[i].udf));
        end

        // ---------------- fill, overflow, drain, flush ----------------
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 0, 0, 8'(i));
            $display("[TB] fill wr=%02h level=%0d wafull=%0b wfull=%0b", 8'(i), level, wafull, wfull);
            check_model("fill");
            chk("fill.wafull_edge", 64'(wafull), 64'(i >= 12));
        end
        chk("fill.wfull16", 64'(wfull), 64'd1);
        cycle(1, 0, 0, 8'hFF);
        $display("[TB] overflow wr=ff level=%0d ovf=%0b", level, ovf);
        chk("ovf.flag", 64'(ovf), 64'd1);
        chk("ovf.level", 64'(level), 64'd16);
        check_model("ovf");
        for (int k = 0; k < 8; k++) begin
            logic [15:0] exp_w;
            exp_w = {8'(2*k+2), 8'(2*k+1)};
            cycle(0, 1, 0, 8'h00);
            $display("[TB] drain rd=%h valid=%0b level=%0d", rd_data, rd_valid, level);
            chk("drain.rd", 64'(rd_data), 64'(exp_w));
            chk("drain.valid", 64'(rd_valid), 64'd1);
            check_model("drain");
            if (k < 7) begin
                cycle(0, 0, 0, 8'h00);
                chk("drain.valid_drop", 64'(rd_valid), 64'd0);
                chk("drain.hold", 64'(rd_data), 64'(exp_w));
            end
        end
        chk("drain.rempty", 64'(rempty), 64'd1);
        cycle(1, 1, 1, 8'h77);
        $display("[TB] flush level=%0d ovf=%0b valid=%0b", level, ovf, rd_valid);
        chk("flush.level", 64'(level), 64'd0);
        chk("flush.ovf", 64'(ovf), 64'd0);
        chk("flush.valid", 64'(rd_valid), 64'd0);
        chk("flush.rd_kept", 64'(rd_data), 64'h100F);
        check_model("flush");

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'(8'h30 + i));
        cycle(1, 1, 0, 8'h34);
        check_model("pre_rst");
        #2 rst = 1;
        #1;
        $display("[TB] async reset level=%0d rd=%h valid=%0b", level, rd_data, rd_valid);
        model_reset();
        check_model("async_rst");
        #3 rst = 0;

        // ---------------- simultaneous traffic, 100 cycles ----------------
        for (int i = 0; i < 100; i++) begin
            cycle(1, 1, 0, 8'(i));
            if (rd_valid) $display("[TB] stream pop %h level=%0d", rd_data, level);
            check_model("stream");
        end
        chk("stream.no_ovf", 64'(ovf), 64'd0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            bit w, r, f;
            if (i < 200) begin
                w = ($urandom_range(0, 9) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            f = ($urandom_range(0, 39) == 0);
            cycle(w, r, f, 8'($urandom));
            if (rd_valid) $display("[TB] rand pop %h level=%0d", rd_data, level);
            check_model("rand");
        end

        // ---------------- RD_RATIO=4, FIFO_DEPTH=8 build ----------------
        for (int i = 0; i < 8; i++) cycle4(1, 0, 8'(8'h10 + i));
        chk("r4.full", 64'(full4), 64'd1);
        chk("r4.level", 64'(lvl4), 64'd8);
        cycle4(0, 1, 8'h00);
        $display("[TB] r4 pop %h valid=%0b", rd4, v4);
        chk("r4.rd0", 64'(rd4), 64'h13121110);
        chk("r4.v0", 64'(v4), 64'd1);
        cycle4(0, 1, 8'h00);
        $display("[TB] r4 pop %h valid=%0b", rd4, v4);
        chk("r4.rd1", 64'(rd4), 64'h17161514);
        chk("r4.empty", 64'(empty4), 64'd1);
        chk("r4.flags", 64'({ovf4, udf4, afull4}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
